microwave_controller: RTL and testbench

Sequencer for the microwave's mm:ss countdown timer: keypad digit entry, start/stop/pause, door interlock, 1 Hz tick generation and the cook-done alarm. It drives the timer's load, clear and enable inputs, watches the timer's zero flag, and switches the magnetron. It sits between the keypad/door/button front end and the timer datapath.

---
 rtl/microwave_controller.sv | 165 ++++++++++++++++
 tb/tb_microwave_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_controller.sv
// Microwave countdown sequencer: keypad digit loading, cook/pause/done control,
// door interlock, 1 Hz tick prescaler and done-alarm timing for the mm:ss timer.
module microwave_controller #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DONE_CYCLES = 150_000_000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] data,
    output logic       loadn,
    output logic       timer_clearn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DC_W  = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [DC_W-1:0]  DC_MAX  = DC_W'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic [DC_W-1:0]   dcnt_q;
    logic [DC_W-1:0]   dcnt_d;
    logic [1:0]        digits_q;
    logic [1:0]        digits_d;
    logic              key_ok;
    logic              key_accept;
    logic              tick;
    logic              enter_idle;

    assign state = state_q;

    // A key is usable only if it is a decimal digit and fewer than three are loaded.
    assign key_ok = key_valid && (key <= 4'd9) && (digits_q < 2'd3);

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; stop outranks the door, which outranks start and keys.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (key_ok) begin
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start && door_closed && !timer_zero) begin
                    state_d = S_COOK;
                end
            end
            S_COOK: begin
                if (stop || !door_closed) begin
                    state_d = S_PAUSE;
                end else if (timer_zero) begin
                    state_d = S_DONE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start && door_closed) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (stop || start || (dcnt_q == DC_MAX)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of counters and strobes derived from the current/next state pair.
    always_comb begin
        enter_idle = (state_d == S_IDLE) && (state_q != S_IDLE);
        // In ENTRY a key loses to a stop or a successful start in the same cycle.
        key_accept = key_ok && ((state_q == S_IDLE) ||
                                ((state_q == S_ENTRY) && (state_d == S_ENTRY)));
        // The wrap only fires when staying in COOK, so a pause or zero flag
        // on the wrap cycle defers/suppresses the tick instead of losing it.
        tick = (state_q == S_COOK) && (state_d == S_COOK) && (pre_q == PRE_MAX);

        pre_d = pre_q;
        if (state_d == S_IDLE) begin
            pre_d = '0;
        end else if ((state_q == S_ENTRY) && (state_d == S_COOK)) begin
            pre_d = '0;
        end else if (state_q == S_COOK) begin
            if (pre_q == PRE_MAX) begin
                if (state_d == S_COOK) begin
                    pre_d = '0;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        dcnt_d = ((state_q == S_DONE) && (state_d == S_DONE)) ? dcnt_q + 1'b1 : '0;

        digits_d = digits_q;
        if (state_d == S_IDLE) begin
            digits_d = '0;
        end else if (key_accept) begin
            digits_d = digits_q + 1'b1;
        end
    end

    // Registered outputs and internal counters.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            data         <= 4'd0;
            loadn        <= 1'b1;
            timer_clearn <= 1'b0;
            timer_enable <= 1'b0;
            mag_on       <= 1'b0;
            done         <= 1'b0;
            pre_q        <= '0;
            dcnt_q       <= '0;
            digits_q     <= '0;
        end else begin
            if (key_accept) begin
                data <= key;
            end
            loadn        <= !key_accept;
            timer_clearn <= !enter_idle;
            timer_enable <= tick;
            mag_on       <= (state_d == S_COOK);
            done         <= (state_d == S_DONE);
            pre_q        <= pre_d;
            dcnt_q       <= dcnt_d;
            digits_q     <= digits_d;
        end
    end

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller with TICK_DIV=4, DONE_CYCLES=8.
module tb_microwave_controller;

    logic       clock;
    logic       clear;
    logic [3:0] key;
    logic       key_valid;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] data;
    logic       loadn;
    logic       timer_clearn;
    logic       timer_enable;
    logic       mag_on;
    logic       done;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    microwave_controller #(.TICK_DIV(4), .DONE_CYCLES(8)) dut (
        .clock       (clock),
        .clear       (clear),
        .key         (key),
        .key_valid   (key_valid),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .data        (data),
        .loadn       (loadn),
        .timer_clearn(timer_clearn),
        .timer_enable(timer_enable),
        .mag_on      (mag_on),
        .done        (done),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then drop the one-cycle pulse inputs.
    task automatic step();
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; key = 4'd0; key_valid = 1'b0; start = 1'b0; stop = 1'b0;
        door_closed = 1'b1; timer_zero = 1'b0;

        // Reset values
        #1;
        chk("rst_state",  state, 0);
        chk("rst_data",   data, 0);
        chk("rst_loadn",  loadn, 1);
        chk("rst_clearn", timer_clearn, 0);
        chk("rst_enable", timer_enable, 0);
        chk("rst_mag",    mag_on, 0);
        chk("rst_done",   done, 0);
        step(); step();
        chk("rst_clearn_held", timer_clearn, 0);
        clear = 1'b0;
        step();
        chk("rel_clearn", timer_clearn, 1);
        chk("rel_state",  state, 0);

        // Entry: keys 1,3,0 then an ignored 4th key
        press(4'd1);
        chk("k1_loadn", loadn, 0); chk("k1_data", data, 1); chk("k1_state", state, 1);
        step();
        chk("k1_loadn_end", loadn, 1);
        press(4'd3);
        chk("k3_loadn", loadn, 0); chk("k3_data", data, 3);
        step();
        chk("k3_loadn_end", loadn, 1);
        press(4'd0);
        chk("k0_loadn", loadn, 0); chk("k0_data", data, 0);
        step();
        press(4'd5);
        chk("k4th_loadn", loadn, 1); chk("k4th_state", state, 1);
        stop = 1'b1;
        step();
        chk("entry_stop_state", state, 0); chk("entry_stop_clearn", timer_clearn, 0);
        step();
        chk("entry_stop_clearn_end", timer_clearn, 1);

        // Invalid key and invalid starts
        press(4'd12);
        chk("k12_loadn", loadn, 1); chk("k12_state", state, 0);
        press(4'd1);
        chk("inv_k1_loadn", loadn, 0); chk("inv_k1_state", state, 1);
        timer_zero = 1'b1; start = 1'b1;
        step();
        chk("start_tz_state", state, 1); chk("start_tz_mag", mag_on, 0);
        timer_zero = 1'b0; door_closed = 1'b0; start = 1'b1;
        step();
        chk("start_door_state", state, 1); chk("start_door_mag", mag_on, 0);
        door_closed = 1'b1;

        // Cook to completion: digits 1,0 loaded, 10 ticks
        press(4'd0);
        chk("cook_k0_loadn", loadn, 0);
        start = 1'b1;
        step();
        chk("cook_state", state, 2); chk("cook_mag", mag_on, 1); chk("cook_en0", timer_enable, 0);
        for (int t = 0; t < 10; t++) begin
            for (int c = 1; c <= 4; c++) begin
                step();
                chk("cook_enable", timer_enable, (c == 4) ? 1 : 0);
                chk("cook_mag_run", mag_on, 1);
            end
        end
        step();
        chk("cook_last_en", timer_enable, 0); chk("cook_last_state", state, 2);
        timer_zero = 1'b1;
        step();
        chk("done_state", state, 4); chk("done_mag", mag_on, 0);
        chk("done_flag", done, 1);   chk("done_en", timer_enable, 0);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("done_hold_state", state, 4); chk("done_hold_flag", done, 1);
        end
        step();
        chk("done_exit_state", state, 0); chk("done_exit_flag", done, 0);
        chk("done_exit_clearn", timer_clearn, 0);
        step();
        chk("done_exit_clearn_end", timer_clearn, 1);
        timer_zero = 1'b0;

        // Interlock: door opens 2 cycles after a tick, resume 2 cycles before next tick
        press(4'd2);
        start = 1'b1;
        step();
        chk("il_state", state, 2);
        step(); step(); step();
        chk("il_pre_en", timer_enable, 0);
        step();
        chk("il_tick", timer_enable, 1);
        step();
        door_closed = 1'b0;
        step();
        chk("il_open_state", state, 3); chk("il_open_mag", mag_on, 0); chk("il_open_en", timer_enable, 0);
        step(); step();
        chk("il_pause_en", timer_enable, 0); chk("il_pause_state", state, 3);
        start = 1'b1;
        step();
        chk("il_open_start_state", state, 3); chk("il_open_start_mag", mag_on, 0);
        door_closed = 1'b1; start = 1'b1;
        step();
        chk("il_resume_state", state, 2); chk("il_resume_mag", mag_on, 1); chk("il_resume_en", timer_enable, 0);
        step();
        chk("il_resume_en1", timer_enable, 0);
        step();
        chk("il_resume_tick", timer_enable, 1);

        // Cancel: stop in COOK pauses, stop again cancels
        stop = 1'b1;
        step();
        chk("cx_pause_state", state, 3); chk("cx_pause_mag", mag_on, 0);
        stop = 1'b1;
        step();
        chk("cx_idle_state", state, 0); chk("cx_idle_clearn", timer_clearn, 0);
        step();
        chk("cx_idle_clearn_end", timer_clearn, 1);
        press(4'd3);
        start = 1'b1;
        step();
        chk("cx2_cook", state, 2);
        stop = 1'b1;
        step();
        chk("cx2_pause", state, 3);
        start = 1'b1; stop = 1'b1;
        step();
        chk("cx2_both_state", state, 0); chk("cx2_both_mag", mag_on, 0);
        step();

        // Async reset mid-COOK on a tick cycle
        press(4'd4);
        start = 1'b1;
        step();
        chk("ar_cook", state, 2);
        step(); step(); step(); step();
        chk("ar_tick", timer_enable, 1);
        #2 clear = 1'b1;
        #1;
        chk("ar_en",     timer_enable, 0);
        chk("ar_mag",    mag_on, 0);
        chk("ar_state",  state, 0);
        chk("ar_loadn",  loadn, 1);
        chk("ar_clearn", timer_clearn, 0);
        @(posedge clock); #1;
        clear = 1'b0;
        #7;
        chk("ar_clearn_low", timer_clearn, 0);
        @(posedge clock); #1;
        chk("ar_clearn_rise", timer_clearn, 1);

        // Async reset during a load pulse
        press(4'd7);
        chk("ar2_loadn_pre", loadn, 0);
        #2 clear = 1'b1;
        #1;
        chk("ar2_loadn", loadn, 1); chk("ar2_data", data, 0); chk("ar2_state", state, 0);
        @(posedge clock); #1;
        clear = 1'b0;
        step();
        chk("ar2_clearn_rise", timer_clearn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
